// File: rtl/life_ctrl_pkg.sv
// life_ctrl_pkg: shared definitions for the game-of-life controller.
//   state_t       - 4-bit state codes, also visible on the controller's
//                   state output.
//   WIN_LIMIT_DEF - default win-timer terminal value (15-bit timer).
package life_ctrl_pkg;

   typedef enum logic [3:0] {
      IDLE     = 4'd0,
      INPUT    = 4'd1,
      READ     = 4'd2,
      WRITE    = 4'd3,
      WRITEOUT = 4'd4,
      PAUSE    = 4'd5,
      WIN      = 4'd6,
      LOSE     = 4'd7,
      WAIT     = 4'd8
   } state_t;

   localparam logic [14:0] WIN_LIMIT_DEF = 15'h65FF;

endpackage

// File: rtl/sat_counter.sv
// sat_counter: up-counter that stops at LIMIT (no wrap).
//   clka     in  clock
//   rst      in  async active-high reset, clears the count
//   inc      in  count up by one when below LIMIT
//   clr      in  synchronous clear, wins over inc
//   at_limit out count == LIMIT
module sat_counter #(
   parameter int           W     = 15,
   parameter logic [W-1:0] LIMIT = '1
) (
   input  logic clka,
   input  logic rst,
   input  logic inc,
   input  logic clr,
   output logic at_limit
);

   logic [W-1:0] cnt;

   assign at_limit = (cnt == LIMIT);

   always_ff @(posedge clka or posedge rst) begin
      if (rst)                    cnt <= '0;
      else if (clr)               cnt <= '0;
      else if (inc && !at_limit)  cnt <= cnt + W'(1);
   end

endmodule

// File: rtl/life_ctrl_fsm.sv
// life_ctrl_fsm: sequences board load, per-cell read/write sweeps with a
// mem_ack handshake, generation write-out and win/lose detection.
//   clka, rst        clock, async active-high reset
//   inp              board load request, overrides everything
//   run              start one generation from IDLE
//   wai              level-sensitive hold request
//   lose_sig         lose condition from datapath
//   mem_ack          completes the current READ/WRITE access
//   load_data/read_data/write_data/write_out/win/lose
//                    Moore strobes decoded from the state register
//   state            current state code
//   addr             current cell index
//   gen_count        completed generations (wraps)
module life_ctrl_fsm
   import life_ctrl_pkg::*;
#(
   parameter int               ADDR_W    = 9,
   parameter int               CELLS     = 16,
   parameter int               WIN_W     = 15,
   parameter logic [WIN_W-1:0] WIN_LIMIT = WIN_W'(WIN_LIMIT_DEF),
   parameter int               GEN_W     = 8
) (
   input  logic              clka,
   input  logic              rst,
   input  logic              inp,
   input  logic              run,
   input  logic              wai,
   input  logic              lose_sig,
   input  logic              mem_ack,
   output logic              load_data,
   output logic              read_data,
   output logic              write_data,
   output logic              write_out,
   output logic              win,
   output logic              lose,
   output logic [3:0]        state,
   output logic [ADDR_W-1:0] addr,
   output logic [GEN_W-1:0]  gen_count
);

   localparam logic [3:0] ST_IDLE     = IDLE;
   localparam logic [3:0] ST_INPUT    = INPUT;
   localparam logic [3:0] ST_READ     = READ;
   localparam logic [3:0] ST_WRITE    = WRITE;
   localparam logic [3:0] ST_WRITEOUT = WRITEOUT;
   localparam logic [3:0] ST_PAUSE    = PAUSE;
   localparam logic [3:0] ST_WIN      = WIN;
   localparam logic [3:0] ST_LOSE     = LOSE;
   localparam logic [3:0] ST_WAIT     = WAIT;

   localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(CELLS - 1);

   logic win_tmr_inc;
   logic win_tmr_max;

   // The win timer only runs while the board is "at rest".
   assign win_tmr_inc = (state == ST_IDLE) || (state == ST_WAIT) ||
                        (state == ST_PAUSE);

   sat_counter #(
      .W     (WIN_W),
      .LIMIT (WIN_LIMIT)
   ) u_win_tmr (
      .clka     (clka),
      .rst      (rst),
      .inc      (win_tmr_inc),
      .clr      (inp),
      .at_limit (win_tmr_max)
   );

   always_ff @(posedge clka or posedge rst) begin
      if (rst) begin
         state     <= ST_IDLE;
         addr      <= '0;
         gen_count <= '0;
      end else if (inp) begin
         state     <= ST_INPUT;
         addr      <= '0;
         gen_count <= '0;
      end else begin
         case (state)
            ST_IDLE: begin
               if (run && (lose_sig || win_tmr_max)) state <= ST_PAUSE;
               else if (run)                         state <= ST_READ;
               else if (wai)                         state <= ST_WAIT;
            end
            ST_INPUT:    state <= ST_WRITEOUT;
            ST_READ:     if (mem_ack) state <= ST_WRITE;
            ST_WRITE: begin
               if (mem_ack) begin
                  if (addr == LAST_ADDR) begin
                     addr      <= '0;
                     gen_count <= gen_count + GEN_W'(1);
                     state     <= ST_WRITEOUT;
                  end else begin
                     addr  <= addr + ADDR_W'(1);
                     state <= ST_READ;
                  end
               end
            end
            ST_WRITEOUT: state <= ST_IDLE;
            ST_PAUSE: begin
               if (win_tmr_max)   state <= ST_WIN;
               else if (lose_sig) state <= ST_LOSE;
            end
            ST_WIN, ST_LOSE: ;   // sticky until inp
            ST_WAIT:     if (!wai) state <= ST_IDLE;
            default:     state <= ST_IDLE;
         endcase
      end
   end

   assign load_data  = (state == ST_INPUT);
   assign read_data  = (state == ST_READ);
   assign write_data = (state == ST_WRITE);
   assign write_out  = (state == ST_WRITEOUT);
   assign win        = (state == ST_WIN);
   assign lose       = (state == ST_LOSE);

endmodule

// File: tb/tb_life_ctrl_fsm.sv
module tb_life_ctrl_fsm;

   localparam int LIM = 20;

   // spec state codes
   localparam int M_IDLE = 0, M_INPUT = 1, M_READ = 2, M_WRITE = 3,
                  M_WOUT = 4, M_PAUSE = 5, M_WIN = 6, M_LOSE = 7, M_WAIT = 8;

   logic clka = 1'b0;
   logic rst, inp, run, wai, lose_sig, mem_ack;

   logic a_ld, a_rd, a_wr, a_wo, a_win, a_lose;
   logic [3:0] a_state;
   logic [3:0] a_addr;
   logic [7:0] a_gen;

   logic b_ld, b_rd, b_wr, b_wo, b_win, b_lose;
   logic [3:0] b_state;
   logic [8:0] b_addr;
   logic [7:0] b_gen;

   int checks = 0;
   int errors = 0;

   always #5 clka = ~clka;

   life_ctrl_fsm #(.ADDR_W(4), .CELLS(16), .WIN_W(5), .WIN_LIMIT(5'd20), .GEN_W(8)) dut_a (
      .clka(clka), .rst(rst), .inp(inp), .run(run), .wai(wai), .lose_sig(lose_sig),
      .mem_ack(mem_ack), .load_data(a_ld), .read_data(a_rd), .write_data(a_wr),
      .write_out(a_wo), .win(a_win), .lose(a_lose), .state(a_state), .addr(a_addr),
      .gen_count(a_gen));

   // single-cell sweep boundary
   life_ctrl_fsm #(.ADDR_W(9), .CELLS(1), .WIN_W(5), .WIN_LIMIT(5'd20), .GEN_W(8)) dut_b (
      .clka(clka), .rst(rst), .inp(inp), .run(run), .wai(wai), .lose_sig(lose_sig),
      .mem_ack(mem_ack), .load_data(b_ld), .read_data(b_rd), .write_data(b_wr),
      .write_out(b_wo), .win(b_win), .lose(b_lose), .state(b_state), .addr(b_addr),
      .gen_count(b_gen));

   // ---------------- reference model ----------------
   typedef struct {
      int st;
      int addr;
      int gen;
      int tmr;
   } mdl_t;

   mdl_t ma, mb;

   function automatic mdl_t step(mdl_t m, bit i, bit r, bit w, bit l, bit a, int cells);
      mdl_t n = m;
      bit   at_lim = (m.tmr == LIM);
      if (i) begin
         n.st = M_INPUT; n.addr = 0; n.gen = 0; n.tmr = 0;
         return n;
      end
      if (m.st == M_IDLE || m.st == M_WAIT || m.st == M_PAUSE)
         n.tmr = (m.tmr + 1 > LIM) ? LIM : m.tmr + 1;
      case (m.st)
         M_IDLE:  if (r && (l || at_lim)) n.st = M_PAUSE;
                  else if (r) n.st = M_READ;
                  else if (w) n.st = M_WAIT;
         M_INPUT: n.st = M_WOUT;
         M_READ:  if (a) n.st = M_WRITE;
         M_WRITE: if (a) begin
                     if (m.addr == cells - 1) begin
                        n.addr = 0; n.gen = (m.gen + 1) % 256; n.st = M_WOUT;
                     end else begin
                        n.addr = m.addr + 1; n.st = M_READ;
                     end
                  end
         M_WOUT:  n.st = M_IDLE;
         M_PAUSE: if (at_lim) n.st = M_WIN;
                  else if (l) n.st = M_LOSE;
         M_WAIT:  if (!w) n.st = M_IDLE;
         default: ;
      endcase
      return n;
   endfunction

   function automatic logic [5:0] strobes(int st);
      return {st == M_INPUT, st == M_READ, st == M_WRITE, st == M_WOUT,
              st == M_WIN, st == M_LOSE};
   endfunction

   task automatic check(string tag, logic [31:0] obs, logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic compare_all();
      check("A.state", 32'(a_state), 32'(ma.st));
      check("A.addr",  32'(a_addr),  32'(ma.addr));
      check("A.gen",   32'(a_gen),   32'(ma.gen));
      check("A.strb",  32'({a_ld, a_rd, a_wr, a_wo, a_win, a_lose}), 32'(strobes(ma.st)));
      check("B.state", 32'(b_state), 32'(mb.st));
      check("B.addr",  32'(b_addr),  32'(mb.addr));
      check("B.gen",   32'(b_gen),   32'(mb.gen));
      check("B.strb",  32'({b_ld, b_rd, b_wr, b_wo, b_win, b_lose}), 32'(strobes(mb.st)));
   endtask

   // drive inputs, clock once, advance models, compare on the falling edge
   task automatic cyc(bit i, bit r, bit w, bit l, bit a);
      inp = i; run = r; wai = w; lose_sig = l; mem_ack = a;
      @(posedge clka);
      ma = step(ma, i, r, w, l, a, 16);
      mb = step(mb, i, r, w, l, a, 1);
      @(negedge clka);
      compare_all();
   endtask

   initial begin
      int n;
      rst = 1'b1; inp = 0; run = 0; wai = 0; lose_sig = 0; mem_ack = 0;
      ma = '{0, 0, 0, 0};
      mb = '{0, 0, 0, 0};
      repeat (2) @(negedge clka);
      compare_all();
      rst = 1'b0;

      // load pulse: INPUT, WRITEOUT, IDLE
      cyc(1, 0, 0, 0, 0);
      check("inp.load_data", 32'(a_ld), 1);
      cyc(0, 0, 0, 0, 0);
      check("inp.write_out", 32'(a_wo), 1);
      cyc(0, 0, 0, 0, 0);
      check("inp.idle", 32'(a_state), M_IDLE);

      // zero-wait sweep: 32 cycles READ/WRITE, then WRITEOUT, IDLE
      cyc(0, 1, 0, 0, 1);
      for (int k = 0; k < 31; k++) cyc(0, 0, 0, 0, 1);
      check("sweep.last_write", 32'(a_state), M_WRITE);
      check("sweep.last_addr", 32'(a_addr), 15);
      cyc(0, 0, 0, 0, 1);
      check("sweep.writeout", 32'(a_state), M_WOUT);
      check("sweep.gen", 32'(a_gen), 1);
      cyc(0, 0, 0, 0, 1);
      check("sweep.idle", 32'(a_state), M_IDLE);

      // ack every 4th cycle, for a few cells
      cyc(0, 1, 0, 0, 0);
      for (int k = 0; k < 40; k++) cyc(0, 0, 0, 0, (k % 4) == 3);
      check("slow.addr", 32'(a_addr), 5);

      // inp coincident with the WRITE ack at addr 7
      n = 0;
      while (!(ma.st == M_WRITE && ma.addr == 7) && n < 100) begin
         cyc(0, 0, 0, 0, 1);
         n++;
      end
      check("abort.reach", 32'(n < 100), 1);
      cyc(1, 0, 0, 0, 1);
      check("abort.state", 32'(a_state), M_INPUT);
      check("abort.addr", 32'(a_addr), 0);
      check("abort.gen", 32'(a_gen), 0);

      // idle past the win limit, then run -> PAUSE -> WIN
      cyc(0, 0, 0, 0, 0);
      for (int k = 0; k < 22; k++) cyc(0, 0, 0, 0, 0);
      cyc(0, 1, 0, 0, 0);
      check("win.pause", 32'(a_state), M_PAUSE);
      cyc(0, 0, 0, 0, 0);
      check("win.flag", 32'(a_win), 1);
      for (int k = 0; k < 5; k++) cyc(0, 1, 1, 1, 1);
      check("win.sticky", 32'(a_win), 1);
      cyc(1, 0, 0, 0, 0);
      check("win.cleared", 32'(a_win), 0);

      // lose path
      cyc(0, 0, 0, 0, 0);
      cyc(0, 0, 0, 0, 0);
      cyc(0, 1, 0, 1, 0);
      check("lose.pause", 32'(a_state), M_PAUSE);
      cyc(0, 0, 0, 1, 0);
      check("lose.flag", 32'({a_lose, a_win}), 2);
      cyc(1, 0, 0, 0, 0);
      check("lose.cleared", 32'({a_state, a_lose}), {4'(M_INPUT), 1'b0});

      // reset mid-sweep aborts at once
      cyc(0, 0, 0, 0, 0);
      cyc(0, 0, 0, 0, 0);
      cyc(0, 1, 0, 0, 1);
      for (int k = 0; k < 10; k++) cyc(0, 0, 0, 0, 1);
      #2 rst = 1'b1;
      #1;
      ma = '{0, 0, 0, 0};
      mb = '{0, 0, 0, 0};
      check("rst.state", 32'(a_state), M_IDLE);
      check("rst.addr", 32'(a_addr), 0);
      @(negedge clka);
      compare_all();
      rst = 1'b0;

      // randomized traffic
      for (int k = 0; k < 800; k++)
         cyc($urandom_range(39) == 0, $urandom_range(2) == 0, $urandom_range(3) == 0,
             $urandom_range(7) == 0, $urandom_range(1) == 0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

// File: doc/life_ctrl_fsm.md
# life_ctrl_fsm

Parametrised single-clock successor to the two-phase game controller: sequences load, per-cell read/write sweeps, generation write-out, and win/lose detection for the cell-array datapath. It replaces the fixed 16-cell, free-running read/write stepping with a configurable sweep length and a `mem_ack` handshake, so slow cell memories are supported. It adds a saturating win timer, a generation counter and explicit `win`/`lose` flags. It sits between the board-input logic and the cell memory/update datapath.

## Interface
Parameters:
- `ADDR_W`, 9: cell address width.
- `CELLS`, 16: cells per sweep; legal range 1 .. 2**ADDR_W.
- `WIN_W`, 15: win-timer width.
- `WIN_LIMIT`, 15'h65FF: win-timer terminal value.
- `GEN_W`, 8: generation counter width.

Ports:
- `clka` in 1: the block's only clock; all state updates on the rising edge.
- `rst` in 1: asynchronous, active-high reset.
- `inp` in 1: board load request; highest priority.
- `run` in 1: start one generation from IDLE.
- `wai` in 1: hold request; level-sensitive.
- `lose_sig` in 1: lose condition from datapath.
- `mem_ack` in 1: completes the current read or write access.
- `load_data` out 1: high in INPUT.
- `read_data` out 1: high in READ.
- `write_data` out 1: high in WRITE.
- `write_out` out 1: high in WRITEOUT.
- `win` out 1: high in WIN.
- `lose` out 1: high in LOSE.
- `state` out 4: current state code.
- `addr` out ADDR_W: current cell index.
- `gen_count` out GEN_W: completed generations.

## Operation
- States: IDLE, INPUT, READ, WRITE, WRITEOUT, PAUSE, WIN, LOSE, WAIT.
- Moore outputs, decoded from the state register; exactly one strobe is high, or none in IDLE, PAUSE and WAIT.
- `inp`=1 from any state: next state INPUT. `addr`, `gen_count` and the win timer are cleared in the same cycle. This overrides every other input, including `mem_ack`.
- IDLE, in priority order:
  - `run`=1 and (`lose_sig`=1 or win timer = WIN_LIMIT) -> PAUSE.
  - `run`=1 -> READ.
  - `wai`=1 -> WAIT.
  - otherwise stay in IDLE.
- INPUT -> WRITEOUT unconditionally.
- READ: stay until `mem_ack`=1, then -> WRITE.
- WRITE: stay until `mem_ack`=1, then:
  - if `addr` = CELLS-1: `addr` <- 0, `gen_count` <- `gen_count`+1 (wraps modulo 2**GEN_W), -> WRITEOUT.
  - else: `addr` <- `addr`+1, -> READ.
- WRITEOUT -> IDLE.
- PAUSE, in priority order:
  - win timer = WIN_LIMIT -> WIN.
  - `lose_sig`=1 -> LOSE.
  - otherwise stay in PAUSE.
- WIN and LOSE are sticky; exit only via `inp`.
- WAIT -> IDLE when `wai`=0.
- Win timer increments by 1 each cycle in IDLE, WAIT or PAUSE, and holds in all other states. It saturates at WIN_LIMIT; no wrap.

## Timing
- Reset values: state IDLE (`state`=0); every strobe, `win`, `lose`, `addr`, `gen_count` and the win timer are 0.
- Input-to-output latency is 1 cycle: an input sampled at edge N changes the state at edge N, and the strobe is visible after edge N.
- `mem_ack` is sampled only in READ/WRITE and ignored elsewhere.
- A zero-wait memory may hold `mem_ack` high continuously. The resulting minimum sweep is 2 cycles/cell, with WRITEOUT 1 cycle after the last WRITE.
- Reset asserted mid-sweep aborts immediately: no WRITEOUT, and `gen_count` is not incremented.
- CELLS=1: every WRITE ack goes to WRITEOUT.

## Structure
- Package `life_ctrl_pkg` holds:
  - the state enum with 4-bit codes IDLE=0, INPUT=1, READ=2, WRITE=3, WRITEOUT=4, PAUSE=5, WIN=6, LOSE=7, WAIT=8;
  - the default WIN_LIMIT constant.
- One sub-module `sat_counter`, parametrised width and limit, with inc, clr and at_limit. It is used for the win timer.

## Test plan
- Reset, then `inp` pulse for 1 cycle: INPUT for 1 cycle with `load_data`=1, then WRITEOUT for 1 cycle, then IDLE. `addr`=0, `gen_count`=0.
- `run` pulse with `mem_ack` tied high, CELLS=16: 32 cycles alternating READ/WRITE with `addr` 0..15, then WRITEOUT, IDLE, `gen_count`=1, `addr`=0.
- `mem_ack` delayed 3 cycles per access: `read_data` held 4 cycles and `write_data` held 4 cycles per cell; `addr` advances only on the WRITE ack.
- `inp` asserted in WRITE at `addr`=7 coincident with `mem_ack`: next state INPUT; `addr`=0 and `gen_count`=0; no WRITEOUT from the aborted sweep.
- Small-limit run (WIN_LIMIT=20, WIN_W=5), idle 20 cycles, then `run`: IDLE -> PAUSE -> WIN, `win`=1 held until `inp`.
- `lose_sig`=1 with `run` in IDLE: PAUSE, then LOSE with `lose`=1 and `win`=0. A later `inp` returns through INPUT and clears `lose`.
